// File: rtl/freelist_if.sv
// Rename-side and commit/recovery-side signal bundle of the physical-register
// free list. The master is the rename/ROB side, the slave is the free list.
`timescale 1ns/1ps
interface freelist_if #(
  parameter int PREG_WIDTH = 6,
  parameter int PTR_WIDTH  = 6
);

  // Rename-stage allocation
  logic                  alloc0_req;
  logic                  alloc1_req;
  logic [PREG_WIDTH-1:0] alloc0_prd;
  logic [PREG_WIDTH-1:0] alloc1_prd;
  logic                  can_alloc;
  logic [PTR_WIDTH-1:0]  free_count;

  // Commit-stage release of previous mappings
  logic                  commits0_valid;
  logic                  commits0_need_to_wb;
  logic [PREG_WIDTH-1:0] commits0_old_prd;
  logic                  commits1_valid;
  logic                  commits1_need_to_wb;
  logic [PREG_WIDTH-1:0] commits1_old_prd;

  // ROB recovery control
  logic [1:0]            rob_state;
  logic                  rob_walk0_valid;
  logic                  rob_walk1_valid;

  // Sticky error
  logic                  overflow_err;

  modport master (
    output alloc0_req, alloc1_req,
    output commits0_valid, commits0_need_to_wb, commits0_old_prd,
    output commits1_valid, commits1_need_to_wb, commits1_old_prd,
    output rob_state, rob_walk0_valid, rob_walk1_valid,
    input  alloc0_prd, alloc1_prd, can_alloc, free_count, overflow_err
  );

  modport slave (
    input  alloc0_req, alloc1_req,
    input  commits0_valid, commits0_need_to_wb, commits0_old_prd,
    input  commits1_valid, commits1_need_to_wb, commits1_old_prd,
    input  rob_state, rob_walk0_valid, rob_walk1_valid,
    output alloc0_prd, alloc1_prd, can_alloc, free_count, overflow_err
  );

endinterface

// File: rtl/freelist.sv
// Physical-register free list, 2-wide allocate / 2-wide release.
// A circular array of free pregs is read at spec_head by rename, refilled at
// tail by commit, and arch_head tracks the oldest uncommitted allocation so
// that ROB recovery can roll spec_head back and then walk it forward again.
`timescale 1ns/1ps
module freelist #(
  parameter int PREG_WIDTH = 6,
  parameter int DEPTH      = 32,
  parameter int PTR_WIDTH  = 6
) (
  input  logic      clock,
  input  logic      reset_n,
  freelist_if.slave fl
);

  localparam int IDX_WIDTH  = PTR_WIDTH - 1;
  // Pregs below this value are the architectural reset mappings.
  localparam int FIRST_FREE = (1 << PREG_WIDTH) - DEPTH;

  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [PTR_WIDTH-1:0]  ptr_t;

  typedef enum logic [1:0] {
    ROB_STATE_IDLE          = 2'd0,
    ROB_STATE_OVERWRITE_RAT = 2'd1,
    ROB_STATE_WALKING       = 2'd2
  } rob_state_e;

  // Storage and pointers (wrap bit is the pointer MSB)
  preg_t entries_q [DEPTH];
  preg_t entries_d [DEPTH];
  ptr_t  spec_head_q, spec_head_d;
  ptr_t  arch_head_q, arch_head_d;
  ptr_t  tail_q,      tail_d;
  logic  overflow_err_q, overflow_err_d;

  // Per-cycle decode
  rob_state_e         rob_state;
  logic               is_idle;
  logic               rel0;
  logic               rel1;
  ptr_t               rel_cnt;
  ptr_t               alloc_cnt;
  ptr_t               walk_cnt;
  ptr_t               free_count;
  logic               can_alloc;
  logic [PTR_WIDTH:0] count_after_rel;
  logic               rel_overflow;
  ptr_t               offer1_ptr;
  ptr_t               tail1_ptr;

  // Decode this cycle's releases, allocations and walk steps.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; the flop block below uses '<=' so all state updates together.
    rob_state  = rob_state_e'(fl.rob_state);
    is_idle    = (rob_state == ROB_STATE_IDLE);

    // Preg 0 is hardwired and must never re-enter the list.
    rel0       = fl.commits0_valid & fl.commits0_need_to_wb & (fl.commits0_old_prd != '0);
    rel1       = fl.commits1_valid & fl.commits1_need_to_wb & (fl.commits1_old_prd != '0);
    rel_cnt    = ptr_t'(rel0) + ptr_t'(rel1);

    free_count = tail_q - spec_head_q;
    can_alloc  = is_idle & (free_count >= ptr_t'(2));
    alloc_cnt  = can_alloc ? (ptr_t'(fl.alloc0_req) + ptr_t'(fl.alloc1_req)) : '0;
    walk_cnt   = ptr_t'(fl.rob_walk0_valid) + ptr_t'(fl.rob_walk1_valid);

    // One extra bit so a count above DEPTH cannot alias back into range.
    count_after_rel = {1'b0, free_count} + {1'b0, rel_cnt};
    rel_overflow    = (rel_cnt != '0) && (count_after_rel > (PTR_WIDTH+1)'(DEPTH));

    // A lone instr1 request takes the head entry.
    offer1_ptr = spec_head_q + ptr_t'(fl.alloc0_req);
    // A lone slot-1 release writes at tail.
    tail1_ptr  = tail_q + ptr_t'(rel0);
  end

  // Next-state: compacted release writes, head/tail movement, recovery.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    entries_d      = entries_q;
    spec_head_d    = spec_head_q;
    arch_head_d    = arch_head_q;
    tail_d         = tail_q;
    overflow_err_d = overflow_err_q;

    if (rel_overflow) begin
      // Releasing into a full list is a bookkeeping error upstream; keep the
      // list intact and flag it.
      overflow_err_d = 1'b1;
    end else begin
      if (rel0) entries_d[tail_q[IDX_WIDTH-1:0]]    = fl.commits0_old_prd;
      if (rel1) entries_d[tail1_ptr[IDX_WIDTH-1:0]] = fl.commits1_old_prd;
      tail_d      = tail_q + rel_cnt;
      // Commits retire the oldest allocations.
      arch_head_d = arch_head_q + rel_cnt;
    end

    case (rob_state)
      // Roll back to the committed point, including this cycle's commits.
      ROB_STATE_OVERWRITE_RAT: spec_head_d = arch_head_d;
      // Re-claim the uncommitted pregs in their original order.
      ROB_STATE_WALKING:       spec_head_d = spec_head_q + walk_cnt;
      default:                 spec_head_d = spec_head_q + alloc_cnt;
    endcase
  end

  // State registers; reset loads the initial free pregs FIRST_FREE.. upward.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is reset on purpose -- its reset contents are the
      // initial free list, not don't-care storage.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= preg_t'(FIRST_FREE + i);
      end
      spec_head_q    <= '0;
      arch_head_q    <= '0;
      tail_q         <= ptr_t'(DEPTH);
      overflow_err_q <= 1'b0;
    end else begin
      entries_q      <= entries_d;
      spec_head_q    <= spec_head_d;
      arch_head_q    <= arch_head_d;
      tail_q         <= tail_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign fl.alloc0_prd   = entries_q[spec_head_q[IDX_WIDTH-1:0]];
  assign fl.alloc1_prd   = entries_q[offer1_ptr[IDX_WIDTH-1:0]];
  assign fl.can_alloc    = can_alloc;
  assign fl.free_count   = free_count;
  assign fl.overflow_err = overflow_err_q;

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for the free list: directed scenarios plus a randomized
// run against a queue-based model (free pregs in offer order, and the
// allocated-but-uncommitted pregs in allocation order).
`timescale 1ns/1ps
module tb_freelist;

  localparam int PREG_WIDTH = 6;
  localparam int DEPTH      = 32;
  localparam int PTR_WIDTH  = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OVW  = 2'd1;
  localparam logic [1:0] ST_WALK = 2'd2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  freelist_if #(.PREG_WIDTH(PREG_WIDTH), .PTR_WIDTH(PTR_WIDTH)) fl_if ();

  freelist #(
    .PREG_WIDTH(PREG_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .fl     (fl_if)
  );

  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model
  int free_q[$];
  int pend_q[$];
  bit ovf_m;

  task automatic model_reset();
    free_q.delete();
    pend_q.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(32 + i);
    ovf_m = 1'b0;
  endtask

  // Applies the inputs currently driven, as the coming clock edge will.
  task automatic model_step();
    int  rels[$];
    int  n_alloc;
    int  n_walk;
    bit  rel_ovf;
    if (fl_if.commits0_valid && fl_if.commits0_need_to_wb && fl_if.commits0_old_prd != 0)
      rels.push_back(int'(fl_if.commits0_old_prd));
    if (fl_if.commits1_valid && fl_if.commits1_need_to_wb && fl_if.commits1_old_prd != 0)
      rels.push_back(int'(fl_if.commits1_old_prd));
    rel_ovf = (rels.size() > 0) && (free_q.size() + rels.size() > DEPTH);
    n_alloc = (fl_if.rob_state == ST_IDLE && free_q.size() >= 2) ?
              int'(fl_if.alloc0_req) + int'(fl_if.alloc1_req) : 0;
    n_walk  = (fl_if.rob_state == ST_WALK) ?
              int'(fl_if.rob_walk0_valid) + int'(fl_if.rob_walk1_valid) : 0;
    repeat (n_alloc) pend_q.push_back(free_q.pop_front());
    if (rel_ovf) begin
      ovf_m = 1'b1;
    end else begin
      foreach (rels[i]) begin
        free_q.push_back(rels[i]);
        void'(pend_q.pop_front());
      end
    end
    if (fl_if.rob_state == ST_OVW) begin
      while (pend_q.size() > 0) free_q.push_front(pend_q.pop_back());
    end
    repeat (n_walk) pend_q.push_back(free_q.pop_front());
  endtask

  task automatic set_idle();
    fl_if.alloc0_req          = 1'b0;
    fl_if.alloc1_req          = 1'b0;
    fl_if.commits0_valid      = 1'b0;
    fl_if.commits0_need_to_wb = 1'b0;
    fl_if.commits0_old_prd    = '0;
    fl_if.commits1_valid      = 1'b0;
    fl_if.commits1_need_to_wb = 1'b0;
    fl_if.commits1_old_prd    = '0;
    fl_if.rob_state           = ST_IDLE;
    fl_if.rob_walk0_valid     = 1'b0;
    fl_if.rob_walk1_valid     = 1'b0;
  endtask

  task automatic set_commits(input logic [PREG_WIDTH-1:0] p0, input logic [PREG_WIDTH-1:0] p1);
    fl_if.commits0_valid      = 1'b1;
    fl_if.commits0_need_to_wb = 1'b1;
    fl_if.commits0_old_prd    = p0;
    fl_if.commits1_valid      = 1'b1;
    fl_if.commits1_need_to_wb = 1'b1;
    fl_if.commits1_old_prd    = p1;
  endtask

  // One clock: update the model, then return at the next falling edge.
  task automatic advance();
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    fl_if.alloc0_req = 1'b1;
    fl_if.alloc1_req = 1'b1;
    @(negedge clock);
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd32) $display("FAIL reset_free_count: got %0d expected 32", fl_if.free_count);
    else checks_passed++;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd32) $display("FAIL reset_alloc0_prd: got %0d expected 32", fl_if.alloc0_prd);
    else checks_passed++;
    checks_total++;
    if (fl_if.alloc1_prd !== 6'd33) $display("FAIL reset_alloc1_prd: got %0d expected 33", fl_if.alloc1_prd);
    else checks_passed++;
    checks_total++;
    if (fl_if.can_alloc !== 1'b1) $display("FAIL reset_can_alloc: got %b expected 1", fl_if.can_alloc);
    else checks_passed++;
    checks_total++;
    if (fl_if.overflow_err !== 1'b0) $display("FAIL reset_overflow_err: got %b expected 0", fl_if.overflow_err);
    else checks_passed++;
    set_idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_drain();
    logic [PREG_WIDTH-1:0] exp0;
    logic [PREG_WIDTH-1:0] exp1;
    for (int i = 0; i < 16; i++) begin
      fl_if.alloc0_req = 1'b1;
      fl_if.alloc1_req = 1'b1;
      exp0 = PREG_WIDTH'(32 + 2 * i);
      exp1 = PREG_WIDTH'(33 + 2 * i);
      #1;
      checks_total++;
      if (fl_if.alloc0_prd !== exp0 || fl_if.alloc1_prd !== exp1)
        $display("FAIL drain_offer cycle %0d: got %0d/%0d expected %0d/%0d",
                 i, fl_if.alloc0_prd, fl_if.alloc1_prd, exp0, exp1);
      else checks_passed++;
      advance();
    end
    set_idle();
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd0) $display("FAIL drain_free_count: got %0d expected 0", fl_if.free_count);
    else checks_passed++;
    checks_total++;
    if (fl_if.can_alloc !== 1'b0) $display("FAIL drain_can_alloc: got %b expected 0", fl_if.can_alloc);
    else checks_passed++;
  endtask

  // Runs from the empty list left by test_drain.
  task automatic test_release_from_empty();
    set_commits(6'd5, 6'd7);
    advance();
    set_idle();
    fl_if.alloc0_req = 1'b1;
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd2) $display("FAIL refill_free_count: got %0d expected 2", fl_if.free_count);
    else checks_passed++;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd5 || fl_if.alloc1_prd !== 6'd7)
      $display("FAIL refill_offer: got %0d/%0d expected 5/7", fl_if.alloc0_prd, fl_if.alloc1_prd);
    else checks_passed++;
    fl_if.alloc0_req = 1'b0;
    fl_if.alloc1_req = 1'b1;
    #1;
    checks_total++;
    if (fl_if.alloc1_prd !== 6'd5) $display("FAIL compaction_alloc1_prd: got %0d expected 5", fl_if.alloc1_prd);
    else checks_passed++;
    advance();
    set_idle();
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd1 || fl_if.alloc0_prd !== 6'd7 || fl_if.can_alloc !== 1'b0)
      $display("FAIL single_alloc: got count %0d prd %0d can %b expected count 1 prd 7 can 0",
               fl_if.free_count, fl_if.alloc0_prd, fl_if.can_alloc);
    else checks_passed++;
  endtask

  task automatic test_recovery();
    do_reset();
    repeat (3) begin
      fl_if.alloc0_req = 1'b1;
      fl_if.alloc1_req = 1'b1;
      advance();
    end
    set_idle();
    set_commits(6'd3, 6'd4);
    advance();
    set_idle();
    fl_if.rob_state  = ST_OVW;
    fl_if.alloc0_req = 1'b1;
    fl_if.alloc1_req = 1'b1;
    #1;
    checks_total++;
    if (fl_if.can_alloc !== 1'b0) $display("FAIL overwrite_can_alloc: got %b expected 0", fl_if.can_alloc);
    else checks_passed++;
    advance();
    set_idle();
    fl_if.rob_state       = ST_WALK;
    fl_if.rob_walk0_valid = 1'b1;
    fl_if.rob_walk1_valid = 1'b1;
    #1;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd34 || fl_if.free_count !== 6'd32)
      $display("FAIL overwrite_rollback: got prd %0d count %0d expected prd 34 count 32",
               fl_if.alloc0_prd, fl_if.free_count);
    else checks_passed++;
    advance();
    advance();
    fl_if.rob_walk0_valid = 1'b0;
    fl_if.rob_walk1_valid = 1'b0;
    #1;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd38 || fl_if.free_count !== 6'd28 || fl_if.can_alloc !== 1'b0)
      $display("FAIL walk_result: got prd %0d count %0d can %b expected prd 38 count 28 can 0",
               fl_if.alloc0_prd, fl_if.free_count, fl_if.can_alloc);
    else checks_passed++;
    fl_if.rob_state = ST_IDLE;
    #1;
    checks_total++;
    if (fl_if.can_alloc !== 1'b1) $display("FAIL walk_back_to_idle: got %b expected 1", fl_if.can_alloc);
    else checks_passed++;
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      fl_if.alloc0_req = 1'b1;
      fl_if.alloc1_req = 1'b1;
      #1;
      checks_total++;
      if (fl_if.free_count !== PTR_WIDTH'(32 - 2 * i))
        $display("FAIL wrap_alloc_count cycle %0d: got %0d expected %0d", i, fl_if.free_count, 32 - 2 * i);
      else checks_passed++;
      advance();
    end
    set_idle();
    for (int i = 0; i < 15; i++) begin
      set_commits(PREG_WIDTH'(2 * i + 1), PREG_WIDTH'(2 * i + 2));
      #1;
      checks_total++;
      if (fl_if.free_count !== PTR_WIDTH'(2 + 2 * i))
        $display("FAIL wrap_release_count cycle %0d: got %0d expected %0d", i, fl_if.free_count, 2 + 2 * i);
      else checks_passed++;
      advance();
    end
    set_idle();
    fl_if.alloc0_req = 1'b1;
    fl_if.alloc1_req = 1'b1;
    #1;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd62 || fl_if.alloc1_prd !== 6'd63)
      $display("FAIL wrap_offer_tail_end: got %0d/%0d expected 62/63", fl_if.alloc0_prd, fl_if.alloc1_prd);
    else checks_passed++;
    advance();
    #1;
    checks_total++;
    if (fl_if.alloc0_prd !== 6'd1 || fl_if.alloc1_prd !== 6'd2)
      $display("FAIL wrap_offer_crossed: got %0d/%0d expected 1/2", fl_if.alloc0_prd, fl_if.alloc1_prd);
    else checks_passed++;
    advance();
    set_idle();
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd28) $display("FAIL wrap_final_count: got %0d expected 28", fl_if.free_count);
    else checks_passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    set_commits(6'd9, 6'd10);
    advance();
    set_idle();
    fl_if.alloc0_req = 1'b1;
    #1;
    checks_total++;
    if (fl_if.overflow_err !== 1'b1) $display("FAIL overflow_set: got %b expected 1", fl_if.overflow_err);
    else checks_passed++;
    checks_total++;
    if (fl_if.free_count !== 6'd32 || fl_if.alloc0_prd !== 6'd32 || fl_if.alloc1_prd !== 6'd33)
      $display("FAIL overflow_dropped: got count %0d prd %0d/%0d expected count 32 prd 32/33",
               fl_if.free_count, fl_if.alloc0_prd, fl_if.alloc1_prd);
    else checks_passed++;
    fl_if.alloc1_req = 1'b1;
    advance();
    set_idle();
    fl_if.commits0_valid      = 1'b1;
    fl_if.commits0_need_to_wb = 1'b1;
    fl_if.commits0_old_prd    = 6'd0;
    fl_if.commits1_valid      = 1'b1;
    fl_if.commits1_need_to_wb = 1'b1;
    fl_if.commits1_old_prd    = 6'd12;
    advance();
    set_idle();
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd31) $display("FAIL preg0_dropped_count: got %0d expected 31", fl_if.free_count);
    else checks_passed++;
    checks_total++;
    if (fl_if.overflow_err !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", fl_if.overflow_err);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    set_commits(6'd20, 6'd21);
    advance();
    set_idle();
    repeat (2) begin
      fl_if.alloc0_req = 1'b1;
      fl_if.alloc1_req = 1'b1;
      advance();
    end
    set_idle();
    fl_if.rob_state = ST_OVW;
    advance();
    fl_if.rob_state       = ST_WALK;
    fl_if.rob_walk0_valid = 1'b1;
    fl_if.rob_walk1_valid = 1'b1;
    advance();
    fl_if.rob_walk0_valid = 1'b0;
    fl_if.rob_walk1_valid = 1'b0;
    #1;
    checks_total++;
    if (fl_if.free_count !== 6'd30 || fl_if.overflow_err !== 1'b1)
      $display("FAIL mid_walk_state: got count %0d ovf %b expected count 30 ovf 1",
               fl_if.free_count, fl_if.overflow_err);
    else checks_passed++;
    #1;
    reset_n = 1'b0;
    #1;
    fl_if.alloc0_req = 1'b1;
    #0;
    checks_total++;
    if (fl_if.free_count !== 6'd32 || fl_if.overflow_err !== 1'b0 ||
        fl_if.alloc0_prd !== 6'd32 || fl_if.alloc1_prd !== 6'd33)
      $display("FAIL async_reset: got count %0d ovf %b prd %0d/%0d expected count 32 ovf 0 prd 32/33",
               fl_if.free_count, fl_if.overflow_err, fl_if.alloc0_prd, fl_if.alloc1_prd);
    else checks_passed++;
    set_idle();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int phase;
    int walk_cycles;
    int n_rel;
    int idx1;
    do_reset();
    phase       = 0;
    walk_cycles = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_idle();
      fl_if.rob_state  = (phase == 0) ? ST_IDLE : (phase == 1) ? ST_OVW : ST_WALK;
      fl_if.alloc0_req = 1'($urandom_range(0, 1));
      fl_if.alloc1_req = 1'($urandom_range(0, 1));
      fl_if.commits0_valid      = ($urandom_range(0, 2) == 0);
      fl_if.commits0_need_to_wb = ($urandom_range(0, 3) != 0);
      fl_if.commits0_old_prd    = ($urandom_range(0, 7) == 0) ? 6'd0 : PREG_WIDTH'($urandom_range(1, 63));
      fl_if.commits1_valid      = ($urandom_range(0, 2) == 0);
      fl_if.commits1_need_to_wb = ($urandom_range(0, 3) != 0);
      fl_if.commits1_old_prd    = ($urandom_range(0, 7) == 0) ? 6'd0 : PREG_WIDTH'($urandom_range(1, 63));
      n_rel = int'(fl_if.commits0_valid && fl_if.commits0_need_to_wb && fl_if.commits0_old_prd != 0) +
              int'(fl_if.commits1_valid && fl_if.commits1_need_to_wb && fl_if.commits1_old_prd != 0);
      if (n_rel > pend_q.size()) begin
        fl_if.commits0_valid = 1'b0;
        fl_if.commits1_valid = 1'b0;
      end
      if (phase == 2) begin
        fl_if.rob_walk0_valid = 1'($urandom_range(0, 1));
        fl_if.rob_walk1_valid = 1'($urandom_range(0, 1));
        if (int'(fl_if.rob_walk0_valid) + int'(fl_if.rob_walk1_valid) > free_q.size()) begin
          fl_if.rob_walk0_valid = 1'b0;
          fl_if.rob_walk1_valid = 1'b0;
        end
      end
      #1;
      checks_total++;
      if (fl_if.free_count !== PTR_WIDTH'(free_q.size()))
        $display("FAIL rand_free_count cycle %0d: got %0d expected %0d", cyc, fl_if.free_count, free_q.size());
      else checks_passed++;
      checks_total++;
      if (fl_if.can_alloc !== (phase == 0 && free_q.size() >= 2))
        $display("FAIL rand_can_alloc cycle %0d: got %b expected %b", cyc, fl_if.can_alloc,
                 (phase == 0 && free_q.size() >= 2));
      else checks_passed++;
      checks_total++;
      if (fl_if.overflow_err !== ovf_m)
        $display("FAIL rand_overflow cycle %0d: got %b expected %b", cyc, fl_if.overflow_err, ovf_m);
      else checks_passed++;
      if (free_q.size() > 0) begin
        checks_total++;
        if (fl_if.alloc0_prd !== PREG_WIDTH'(free_q[0]))
          $display("FAIL rand_alloc0_prd cycle %0d: got %0d expected %0d", cyc, fl_if.alloc0_prd, free_q[0]);
        else checks_passed++;
      end
      idx1 = int'(fl_if.alloc0_req);
      if (free_q.size() > idx1) begin
        checks_total++;
        if (fl_if.alloc1_prd !== PREG_WIDTH'(free_q[idx1]))
          $display("FAIL rand_alloc1_prd cycle %0d: got %0d expected %0d", cyc, fl_if.alloc1_prd, free_q[idx1]);
        else checks_passed++;
      end
      advance();
      case (phase)
        0: if ($urandom_range(0, 15) == 0) phase = 1;
        1: begin
          phase       = 2;
          walk_cycles = $urandom_range(1, 6);
        end
        default: begin
          walk_cycles--;
          if (walk_cycles <= 0) phase = 0;
        end
      endcase
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    set_idle();
    test_reset();
    test_drain();
    test_release_from_empty();
    test_recovery();
    test_wrap();
    test_overflow();
    test_reset_mid_walk();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/freelist.md
Name: freelist

Overview:
- Physical-register free list that supplies new destination pregs to the rename stage. These become the rename-write data into the speculative rename table.
- Reclaims the previous mapping of each committed destination.
- Restores its speculative allocation pointer during ROB recovery (overwrite-RAT, then walk), in lock-step with the rename table.
- Sits between decode/rename and the RAT; 2-wide alloc, 2-wide release.

Parameters:
- PREG_WIDTH, 6, physical register index width (64 pregs).
- DEPTH, 32, free-list entries (number of pregs minus 32 architectural).
- PTR_WIDTH, 6, log2(DEPTH)+1; MSB is the wrap bit.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- alloc0_req  in  1  instr0 needs a new preg (need_to_wb & valid & fire)
- alloc1_req  in  1  instr1 needs a new preg
- alloc0_prd  out  PREG_WIDTH  preg offered to instr0
- alloc1_prd  out  PREG_WIDTH  preg offered to instr1
- can_alloc  out  1  at least 2 free entries and rob_state idle
- free_count  out  PTR_WIDTH  current speculative free entries
- commits0_valid  in  1  commit slot 0 valid
- commits0_need_to_wb  in  1  slot 0 wrote a register
- commits0_old_prd  in  PREG_WIDTH  preg previously mapped to slot-0 lrd; released on commit
- commits1_valid / commits1_need_to_wb / commits1_old_prd  in  1/1/PREG_WIDTH  same for slot 1
- rob_state  in  2  ROB_STATE_IDLE / ROB_STATE_OVERWRITE_RAT / ROB_STATE_WALKING
- rob_walk0_valid  in  1  walk slot 0 re-applies an uncommitted rename
- rob_walk1_valid  in  1  walk slot 1 re-applies an uncommitted rename
- overflow_err  out  1  sticky: release attempted into full list

Behaviour:
- Storage: DEPTH x PREG_WIDTH circular array plus three pointers (PTR_WIDTH bits each): spec_head, arch_head, tail.
- Reset (async, reset_n low):
  - entry[i] = 32+i; spec_head = arch_head = 0; tail = DEPTH (wrap bit set, index 0).
  - Resulting outputs: overflow_err = 0; free_count = 32; alloc0_prd = 32; alloc1_prd = 33; can_alloc = 1.
  - Reset asserted mid-operation discards all state immediately.
- free_count = tail - spec_head (modulo 2^PTR_WIDTH). List is full when count == DEPTH, empty when 0.
- Offer (combinational from registered state, 0-cycle latency):
  - alloc0_prd = entry[spec_head].
  - alloc1_prd = entry[spec_head + alloc0_req] (compaction: a lone instr1 request takes the head entry).
- Allocate (idle only):
  - When is_idle & can_alloc, spec_head advances by alloc0_req + alloc1_req at posedge.
  - Requests with can_alloc = 0 are ignored; upstream must stall.
  - can_alloc = is_idle & (free_count >= 2).
- Release (any rob_state): rel0 = commits0_valid & commits0_need_to_wb; rel1 likewise.
  - Writes are compacted: slot-0 release writes entry[tail]; slot-1 writes entry[tail + rel0].
  - tail advances by rel0 + rel1.
  - arch_head advances by the same count (commits consume the oldest allocations).
  - If free_count + rel0 + rel1 > DEPTH: set overflow_err and drop the writes; tail holds.
- Recovery:
  - While rob_state == OVERWRITE_RAT: spec_head <= arch_head; allocation blocked.
  - While WALKING: spec_head advances by rob_walk0_valid + rob_walk1_valid per cycle (walk re-claims uncommitted pregs in order); allocation blocked.
  - Commits in the same cycle still release normally.
  - OVERWRITE and a commit in the same cycle: spec_head takes the post-commit arch_head value (arch_head + rel0 + rel1).
- Simultaneous alloc and release in the same cycle are both applied. Count changes by releases minus allocs; an entry released this cycle is not offered until the next cycle.
- Pointer wrap: index = ptr[PTR_WIDTH-2:0]; the wrap bit toggles on overflow past DEPTH-1.
- Pregs 0..31 are never in the list at reset. Preg 0 must never be released: a release of old_prd == 0 is dropped and does not advance tail or arch_head.

Test Plan:
- Reset, no activity -> alloc0_prd=32, alloc1_prd=33, free_count=32, can_alloc=1, overflow_err=0.
- 16 cycles of alloc0_req=alloc1_req=1 -> pregs 32..63 issued in order; then free_count=0, can_alloc=0.
- From empty, commit slot0 old_prd=5 and slot1 old_prd=7 (both need_to_wb) -> next cycle free_count=2, alloc0_prd=5, alloc1_prd=7; alloc1_req alone next -> alloc1_prd=5.
- Allocate 6 (32..37), commit 2 releasing 3 and 4, then OVERWRITE_RAT for 1 cycle -> spec_head=arch_head=2, alloc0_prd=34; then WALKING with both walk valids for 2 cycles -> alloc0_prd=38, free_count=28, can_alloc=0 until IDLE.
- Wrap: allocate 30, release 30, allocate 4 -> offered pregs cross index 31->0 correctly; free_count stays consistent (32 - in-flight).
- Full list plus commits release of 2 -> overflow_err=1 sticky; tail unchanged; reset_n low mid-walk -> all state returns to reset values immediately.
